// File: rtl/seq_pkg.sv
// Shared types for the instruction sequencer: opcodes, FSM states, decode
// classes and instruction field positions.
package seq_pkg;

  localparam int OPC_MSB = 19;
  localparam int OPC_LSB = 16;
  localparam int ARG_W   = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDA  = 4'h1,
    OP_NAD  = 4'h2,
    OP_SHL  = 4'h3,
    OP_SHR  = 4'h4,
    OP_RD   = 4'h5,
    OP_WR   = 4'h6,
    OP_JMP  = 4'h7,
    OP_JZ   = 4'h8,
    OP_JNZ  = 4'h9,
    OP_CALL = 4'hA,
    OP_RET  = 4'hB,
    OP_ILLC = 4'hC,
    OP_ILLD = 4'hD,
    OP_ILLE = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    JC_NONE,
    JC_JMP,
    JC_JZ,
    JC_JNZ,
    JC_CALL,
    JC_RET,
    JC_HALT
  } jump_e;

  typedef struct packed {
    logic arg;
    logic nad;
    logic shl;
    logic shr;
    logic read;
    logic write;
    logic acc;
  } strobes_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decoder: strobe set, jump class and illegal flag.
// CALL/RET are only legal when SEQUENCER_CALL_EN is defined.
module seq_decode
  import seq_pkg::*;
(
  input  logic [3:0] opcode,
  output strobes_t   strobes,
  output jump_e      jump,
  output logic       illegal
);

  opcode_e op;
  assign op = opcode_e'(opcode);

  always_comb begin
    strobes = '0;
    jump    = JC_NONE;
    illegal = 1'b0;
    case (op)
      OP_NOP: ;
      OP_LDA: begin strobes.arg   = 1'b1; strobes.acc = 1'b1; end
      OP_NAD: begin strobes.nad   = 1'b1; strobes.acc = 1'b1; end
      OP_SHL: begin strobes.shl   = 1'b1; strobes.acc = 1'b1; end
      OP_SHR: begin strobes.shr   = 1'b1; strobes.acc = 1'b1; end
      OP_RD:  begin strobes.read  = 1'b1; strobes.acc = 1'b1; end
      OP_WR:  strobes.write = 1'b1;
      OP_JMP: jump = JC_JMP;
      OP_JZ:  jump = JC_JZ;
      OP_JNZ: jump = JC_JNZ;
`ifdef SEQUENCER_CALL_EN
      OP_CALL: jump = JC_CALL;
      OP_RET:  jump = JC_RET;
`else
      OP_CALL: illegal = 1'b1;
      OP_RET:  illegal = 1'b1;
`endif
      OP_HALT: jump = JC_HALT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sequencer.sv
// Fetch/execute instruction sequencer with an optional return stack
// (enabled by defining SEQUENCER_CALL_EN).
module sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [19:0]       imem_data,
  output logic [ARG_W-1:0]  arg,
  output logic              ctl_arg,
  output logic              ctl_nad,
  output logic              ctl_shl,
  output logic              ctl_shr,
  output logic              ctl_read,
  output logic              ctl_write,
  output logic              ctl_acc,
  input  logic              is_zero,
  output logic              halted,
  output logic              error,
  output logic [ADDR_W-1:0] pc
);

  state_e             state;
  logic [OPC_MSB:0]   ir;
  logic               zf;
  strobes_t           dec_strobes;
  strobes_t           exec_strobes;
  jump_e              dec_jump;
  logic               dec_illegal;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  target;

  seq_decode u_decode (
    .opcode  (ir[OPC_MSB:OPC_LSB]),
    .strobes (dec_strobes),
    .jump    (dec_jump),
    .illegal (dec_illegal)
  );

  assign pc_inc    = pc + ADDR_W'(1);
  assign target    = ir[ADDR_W-1:0];
  assign arg       = ir[ARG_W-1:0];
  assign imem_addr = pc;

  assign exec_strobes = (state == ST_EXEC) ? dec_strobes : '0;
  assign {ctl_arg, ctl_nad, ctl_shl, ctl_shr, ctl_read, ctl_write, ctl_acc} = exec_strobes;

`ifdef SEQUENCER_CALL_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_dec;
  logic              stack_full;
  logic              stack_empty;
  logic              push;

  assign sp_dec      = sp - SP_W'(1);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign push        = (state == ST_EXEC) && !dec_illegal && (dec_jump == JC_CALL) && !stack_full;

  // Stack contents need no reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (push) stack_mem[sp[IDX_W-1:0]] <= pc_inc;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc       <= '0;
      ir       <= '0;
      zf       <= 1'b0;
      error    <= 1'b0;
      halted   <= 1'b0;
      imem_req <= 1'b0;
`ifdef SEQUENCER_CALL_EN
      sp       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem_valid) begin
            ir       <= imem_data;
            state    <= ST_EXEC;
            imem_req <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (dec_strobes.acc) zf <= is_zero;
          state    <= ST_FETCH;
          imem_req <= 1'b1;
          pc       <= pc_inc;
          if (dec_illegal) begin
            state    <= ST_HALT;
            imem_req <= 1'b0;
            halted   <= 1'b1;
            error    <= 1'b1;
            pc       <= pc;
          end else begin
            case (dec_jump)
              JC_JMP: pc <= target;
              JC_JZ:  if (zf)  pc <= target;
              JC_JNZ: if (!zf) pc <= target;
              JC_HALT: begin
                state    <= ST_HALT;
                imem_req <= 1'b0;
                halted   <= 1'b1;
                pc       <= pc;
              end
`ifdef SEQUENCER_CALL_EN
              JC_CALL: begin
                if (stack_full) begin
                  state    <= ST_HALT;
                  imem_req <= 1'b0;
                  halted   <= 1'b1;
                  error    <= 1'b1;
                  pc       <= pc;
                end else begin
                  sp <= sp + SP_W'(1);
                  pc <= target;
                end
              end
              JC_RET: begin
                if (stack_empty) begin
                  state    <= ST_HALT;
                  imem_req <= 1'b0;
                  halted   <= 1'b1;
                  error    <= 1'b1;
                  pc       <= pc;
                end else begin
                  sp <= sp_dec;
                  pc <= stack_mem[sp_dec[IDX_W-1:0]];
                end
              end
`endif
              default: ;
            endcase
          end
        end
        ST_HALT: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequencer.sv
// Self-checking bench for sequencer: directed scenarios plus a randomized
// instruction stream compared against an instruction-level reference model.
module tb_sequencer;

`ifdef SEQUENCER_CALL_EN
  localparam bit CALL_EN = 1'b1;
`else
  localparam bit CALL_EN = 1'b0;
`endif
  localparam int DEPTH = 4;
  localparam int PC_MOD = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        imem_valid = 1'b0;
  logic [19:0] imem_data = '0;
  logic        is_zero = 1'b0;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic [15:0] arg;
  logic        ctl_arg, ctl_nad, ctl_shl, ctl_shr, ctl_read, ctl_write, ctl_acc;
  logic        halted, error;
  logic [11:0] pc;

  // Second instance with a 4-bit program counter fed only NOPs.
  logic        valid4 = 1'b1;
  logic [19:0] data4 = '0;
  logic        zero4 = 1'b0;
  logic        imem_req4;
  logic [3:0]  imem_addr4;
  logic [15:0] arg4;
  logic        c4_arg, c4_nad, c4_shl, c4_shr, c4_read, c4_write, c4_acc;
  logic        halted4, error4;
  logic [3:0]  pc4;

  int checks = 0;
  int errors = 0;

  int          mpc;
  bit          mzf, mhalt, merr;
  int          mstack[$];
  logic [15:0] marg;

  wire [6:0] strb = {ctl_arg, ctl_nad, ctl_shl, ctl_shr, ctl_read, ctl_write, ctl_acc};

  always #5 clk = ~clk;

  sequencer dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .arg(arg),
    .ctl_arg(ctl_arg), .ctl_nad(ctl_nad), .ctl_shl(ctl_shl), .ctl_shr(ctl_shr),
    .ctl_read(ctl_read), .ctl_write(ctl_write), .ctl_acc(ctl_acc),
    .is_zero(is_zero), .halted(halted), .error(error), .pc(pc)
  );

  sequencer #(.ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req4), .imem_addr(imem_addr4),
    .imem_valid(valid4), .imem_data(data4),
    .arg(arg4),
    .ctl_arg(c4_arg), .ctl_nad(c4_nad), .ctl_shl(c4_shl), .ctl_shr(c4_shr),
    .ctl_read(c4_read), .ctl_write(c4_write), .ctl_acc(c4_acc),
    .is_zero(zero4), .halted(halted4), .error(error4), .pc(pc4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe set per opcode, ordered {arg,nad,shl,shr,read,write,acc}.
  function automatic logic [6:0] exp_strobes(input int op);
    case (op)
      1: return 7'b1000001;
      2: return 7'b0100001;
      3: return 7'b0010001;
      4: return 7'b0001001;
      5: return 7'b0000101;
      6: return 7'b0000010;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic do_reset();
    #2 rst = 1'b1;
    run = 1'b0;
    imem_valid = 1'b0;
    #1;
    check("reset_pc", pc, 0);
    check("reset_req", imem_req, 0);
    check("reset_halted", halted, 0);
    check("reset_error", error, 0);
    check("reset_arg", arg, 0);
    check("reset_strobes", strb, 0);
    @(negedge clk);
    rst = 1'b0;
    mpc = 0; mzf = 0; mhalt = 0; merr = 0; marg = '0;
    mstack.delete();
    $display("reset applied");
  endtask

  // Entered at a falling edge with the DUT in FETCH; leaves one instruction later.
  task automatic exec_instr(input logic [19:0] word, input int delay, input bit zbit);
    int op;
    int tgt;
    int inc;
    op  = int'(word[19:16]);
    tgt = int'(word[11:0]);
    inc = (mpc + 1) % PC_MOD;
    for (int d = 0; d < delay; d++) begin
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, mpc);
      check("wait_strobes", strb, 0);
      check("wait_arg", arg, marg);
      imem_valid = 1'b0;
      imem_data  = 20'($urandom);
      @(negedge clk);
    end
    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, mpc);
    imem_valid = 1'b1;
    imem_data  = word;
    @(negedge clk);
    check("exec_strobes", strb, exp_strobes(op));
    check("exec_arg", arg, word[15:0]);
    check("exec_req", imem_req, 0);
    imem_valid = 1'($urandom);
    imem_data  = 20'($urandom);
    is_zero    = zbit;
    marg       = word[15:0];
    case (op)
      7: mpc = tgt;
      8: mpc = mzf ? tgt : inc;
      9: mpc = !mzf ? tgt : inc;
      10: begin
        if (CALL_EN && mstack.size() < DEPTH) begin
          mstack.push_back(inc);
          mpc = tgt;
        end else begin
          mhalt = 1; merr = 1;
        end
      end
      11: begin
        if (CALL_EN && mstack.size() > 0) mpc = mstack.pop_back();
        else begin mhalt = 1; merr = 1; end
      end
      12, 13, 14: begin mhalt = 1; merr = 1; end
      15: mhalt = 1;
      default: mpc = inc;
    endcase
    if (op >= 1 && op <= 5) mzf = zbit;
    @(negedge clk);
    check("next_pc", pc, mpc);
    check("next_halted", halted, mhalt);
    check("next_error", error, merr);
    check("next_req", imem_req, !mhalt);
    $display("instr word=%05h delay=%0d z=%0d -> pc=%0d halted=%0d error=%0d",
             word, delay, zbit, pc, halted, error);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int op;
    @(negedge clk);
    do_reset();

    // Stays idle without run.
    repeat (2) @(negedge clk);
    check("idle_req", imem_req, 0);
    check("idle_pc", pc, 0);

    // LDA 0 then JZ 5, fetch always ready.
    run = 1'b1;
    @(negedge clk);
    exec_instr(20'h1_0000, 0, 1'b1);
    exec_instr(20'h8_0005, 0, 1'b0);
    check("jz_taken_pc", pc, 5);

    // Fetch stall of three cycles, then WR 0x0042.
    exec_instr(20'h6_0042, 3, 1'b1);
    check("wr_strobe_gone", ctl_write, 0);

    // Randomized instruction stream.
    for (int i = 0; i < 40; i++) begin
      logic [19:0] word;
      op = CALL_EN ? int'($urandom_range(0, 11)) : int'($urandom_range(0, 9));
      if (op == 10 && mstack.size() >= DEPTH) op = 0;
      if (op == 11 && mstack.size() == 0) op = 0;
      word = {4'(op), 16'($urandom)};
      exec_instr(word, int'($urandom_range(0, 2)), 1'($urandom));
    end
    exec_instr(20'hF_0000, 1, 1'b0);
    check("halt_op_halted", halted, 1);
    check("halt_op_error", error, 0);

    // Reset during EXEC of an LDA.
    do_reset();
    run = 1'b1;
    @(negedge clk);
    imem_valid = 1'b1;
    imem_data  = 20'h1_1234;
    @(negedge clk);
    check("midexec_acc", ctl_acc, 1);
    do_reset();

    // zf cleared by reset: JZ falls through; then illegal 0xD at pc=3.
    run = 1'b1;
    @(negedge clk);
    exec_instr(20'h8_0009, 0, 1'b0);
    check("jz_after_reset_pc", pc, 1);
    exec_instr(20'h0_0000, 0, 1'b0);
    exec_instr(20'h0_0000, 1, 1'b0);
    exec_instr(20'hD_0077, 0, 1'b0);
    check("illegal_halted", halted, 1);
    check("illegal_error", error, 1);
    check("illegal_pc", pc, 3);
    for (int k = 0; k < 3; k++) begin
      run = 1'b0;
      imem_valid = 1'b1;
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      check("halt_hold_halted", halted, 1);
      check("halt_hold_pc", pc, 3);
      check("halt_hold_req", imem_req, 0);
      check("halt_hold_strobes", strb, 0);
    end
    do_reset();

    // Return stack behaviour.
    run = 1'b1;
    @(negedge clk);
`ifdef SEQUENCER_CALL_EN
    exec_instr(20'hA_0200, 0, 1'b0);
    exec_instr(20'hB_0000, 0, 1'b0);
    check("ret_pc", pc, 1);
    exec_instr(20'hB_0000, 0, 1'b0);
    check("ret_empty_error", error, 1);
    do_reset();
    run = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) exec_instr({4'hA, 16'(12'h100 + k * 16)}, 0, 1'b0);
    check("call_overflow_error", error, 1);
    check("call_overflow_pc", pc, 12'h130);
`else
    exec_instr(20'hA_0200, 0, 1'b0);
    check("call_disabled_error", error, 1);
    check("call_disabled_pc", pc, 0);
`endif
    do_reset();

    // 4-bit pc wraps from 15 to 0; main instance waits in FETCH.
    run = 1'b1;
    n = 0;
    while (pc4 != 4'd15 && n < 100) begin @(negedge clk); n++; end
    check("wrap_reach15", pc4, 15);
    n = 0;
    while (pc4 == 4'd15 && n < 10) begin @(negedge clk); n++; end
    check("wrap_to_zero", pc4, 0);
    check("long_stall_req", imem_req, 1);
    check("long_stall_pc", pc, 0);
    check("long_stall_strobes", strb, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequencer.md
SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 Parameter ADDR_W, default 12, program-counter and instruction-address width.
REQ-002 Parameter STACK_DEPTH, default 4, return-stack entries (used only under REQ-030).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 run  input  1  level; leaves IDLE when high.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_addr  output  ADDR_W  fetch address (= pc).
REQ-008 imem_valid  input  1  instruction word present on imem_data.
REQ-009 imem_data  input  20  instruction word: [19:16] opcode, [15:0] operand.
REQ-010 arg  output  16  operand of the current instruction, to the datapath.
REQ-011 ctl_arg, ctl_nad, ctl_shl, ctl_shr, ctl_read, ctl_write, ctl_acc  output  1 each  datapath strobes.
REQ-012 is_zero  input  1  datapath zero indication.
REQ-013 halted  output  1  high in HALT.
REQ-014 error  output  1  sticky; high after an illegal opcode or a stack fault.
REQ-015 pc  output  ADDR_W  current program counter.

Function
REQ-016 FSM states: IDLE, FETCH, EXEC, HALT.
REQ-017 IDLE: go to FETCH on the first edge with run=1.
REQ-018 FETCH: imem_req=1 and imem_addr=pc.
REQ-019 FETCH exit: on an edge with imem_valid=1, latch imem_data into ir and go to EXEC; otherwise stay in FETCH for any number of cycles.
REQ-020 imem_valid shall be ignored outside FETCH.
REQ-021 EXEC lasts exactly one cycle; strobes are driven combinationally from ir and are zero in every other state.
REQ-022 Opcode decode (strobes asserted):
- 0 NOP: none.
- 1 LDA: ctl_arg, ctl_acc.
- 2 NAD: ctl_nad, ctl_acc.
- 3 SHL: ctl_shl, ctl_acc.
- 4 SHR: ctl_shr, ctl_acc.
- 5 RD: ctl_read, ctl_acc.
- 6 WR: ctl_write.
- 7 JMP; 8 JZ; 9 JNZ; A CALL; B RET; F HALT.
- C, D, E: illegal.
REQ-023 arg shall equal ir[15:0] from latch until the next latch, stable across FETCH.
REQ-024 Zero flag zf: at the end of each EXEC that asserts ctl_acc, zf is loaded from is_zero; otherwise zf holds.
REQ-025 Next pc after EXEC:
- JMP: ir[ADDR_W-1:0].
- JZ: the target if zf=1, else pc+1.
- JNZ: the target if zf=0, else pc+1.
- All other opcodes: pc+1, modulo 2^ADDR_W (wraps to 0).
REQ-026 After EXEC the FSM returns to FETCH, except: HALT opcode and illegal opcodes go to HALT with pc unchanged, and illegal opcodes also set error.
REQ-027 HALT is left only by reset; run is ignored in HALT.
REQ-028 Instruction throughput: minimum 2 cycles per instruction (FETCH with imem_valid=1, then EXEC).

Reset
REQ-029 Assertion of rst, asynchronous and at any point including mid-FETCH or EXEC, shall force: state=IDLE, pc=0, ir=0, arg=0, zf=0, error=0, halted=0, stack pointer=0, imem_req=0, all strobes 0.

Configuration
REQ-030 Macro SEQUENCER_CALL_EN defined:
- CALL pushes pc+1 onto the return stack and jumps to ir[ADDR_W-1:0].
- RET pops the stack into pc.
- CALL with the stack full, or RET with it empty, goes to HALT with error=1.
REQ-031 SEQUENCER_CALL_EN undefined: CALL and RET are illegal opcodes (REQ-026), and no stack storage is synthesized.

Structure
REQ-032 Shared package seq_pkg holds:
- The opcode enumeration.
- The FSM state typedef.
- Field constants OPC_MSB=19, OPC_LSB=16, ARG_W=16.
REQ-033 One sub-module, seq_decode: purely combinational, mapping opcode to the strobe set, jump class and illegal flag.

Verification
REQ-034 Reset, then run=1, imem_valid held 1, program LDA 0x0000 -> at the LDA EXEC cycle ctl_arg=ctl_acc=1 and arg=0x0000; the following JZ 5 goes to pc=5.
REQ-035 imem_valid withheld 3 cycles in FETCH -> imem_req stays 1, imem_addr stable, all strobes 0, no EXEC until imem_valid=1.
REQ-036 WR 0x0042 -> exactly one cycle with ctl_write=1 and arg=0x0042; ctl_acc=0.
REQ-037 Opcode 0xD at pc=3 -> halted=1, error=1, pc=3; further run pulses have no effect; rst clears all outputs.
REQ-038 ADDR_W=4 with NOPs -> pc wraps 15->0.
REQ-039 SEQUENCER_CALL_EN defined: 5 nested CALLs with STACK_DEPTH=4 -> error on the 5th. With the macro undefined, the first CALL -> error.
